// File: rtl/cnn_layer_accel_awe_pkg.sv
// Shared definitions for the AWE weight sequencer and its weight table.
package cnn_layer_accel_awe_pkg;

  localparam int unsigned AWE_WIDTH   = 32;
  localparam int unsigned AWE_N_DEPTH = 256;
  localparam int unsigned AWE_W_DEPTH = 8;
  localparam int unsigned AWE_P_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOADED = 2'd2,
    ST_RUN    = 2'd3
  } awe_state_t;

endpackage

// File: rtl/cnn_layer_accel_awe_rd_ctr.sv
// Replay read counter: walks the table address 0..num_wts-1, wrapping once
// per pass, and flags the last word of a pass and the final pass.
module cnn_layer_accel_awe_rd_ctr
  import cnn_layer_accel_awe_pkg::*;
#(
  parameter int unsigned W_DEPTH = AWE_W_DEPTH,
  parameter int unsigned P_WIDTH = AWE_P_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  input  logic [W_DEPTH:0]   num_wts,
  input  logic [P_WIDTH-1:0] num_passes,
  output logic [W_DEPTH-1:0] addr,
  output logic               last,
  output logic               last_pass
);

  localparam logic [W_DEPTH:0]   PTR_ONE  = (W_DEPTH+1)'(1);
  localparam logic [P_WIDTH-1:0] PASS_ONE = P_WIDTH'(1);

  // One extra pointer bit so a full-depth table never overflows.
  logic [W_DEPTH:0]   rd_ptr;
  logic [P_WIDTH-1:0] pass_cnt;

  assign last      = (rd_ptr == num_wts - PTR_ONE);
  assign last_pass = (pass_cnt == num_passes - PASS_ONE);
  assign addr      = rd_ptr[W_DEPTH-1:0];

  // Advance the pointer on each issued read; wrap and count a pass at the end.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr   <= '0;
      pass_cnt <= '0;
    end else if (advance) begin
      if (last) begin
        rd_ptr   <= '0;
        pass_cnt <= pass_cnt + PASS_ONE;
      end else begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_awe_weight_seq.sv
// AWE weight sequencer: loads a kernel's weights into the weight table over a
// valid/ready stream, then replays them in address order for a number of passes.
module cnn_layer_accel_awe_weight_seq
  import cnn_layer_accel_awe_pkg::*;
#(
  parameter int unsigned WIDTH   = AWE_WIDTH,
  parameter int unsigned N_DEPTH = AWE_N_DEPTH,
  parameter int unsigned W_DEPTH = AWE_W_DEPTH,
  parameter int unsigned P_WIDTH = AWE_P_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [W_DEPTH:0]   cfg_num_wts,
  input  logic               wt_in_valid,
  input  logic [WIDTH-1:0]   wt_in_data,
  output logic               wt_in_ready,
  input  logic               run_start,
  input  logic [P_WIDTH-1:0] run_num_passes,
  input  logic               run_stall,
  output logic               wt_out_valid,
  output logic [WIDTH-1:0]   wt_out_data,
  output logic               wt_out_last,
  output logic               wt_out_last_pass,
  output logic               busy,
  output logic               done,
  output logic [W_DEPTH-1:0] tbl_addr,
  output logic               tbl_we,
  output logic [WIDTH-1:0]   tbl_din,
  input  logic [WIDTH-1:0]   tbl_dout
);

  localparam logic [W_DEPTH:0] PTR_ONE = (W_DEPTH+1)'(1);
  localparam logic [W_DEPTH:0] NMAX    = (W_DEPTH+1)'(N_DEPTH);

  awe_state_t         state;
  logic [W_DEPTH:0]   num_wts;
  logic [W_DEPTH:0]   wr_ptr;
  logic [P_WIDTH-1:0] num_passes;

  logic               cfg_ok;
  logic               run_go;
  logic               load_acc;
  logic               issue;
  logic [W_DEPTH-1:0] rd_addr;
  logic               rd_last;
  logic               rd_last_pass;

  assign cfg_ok   = cfg_load && (cfg_num_wts != '0) && (cfg_num_wts <= NMAX);
  // A valid reload in LOADED takes priority over a simultaneous run_start.
  assign run_go   = (state == ST_LOADED) && !cfg_ok && run_start && (run_num_passes != '0);
  assign load_acc = (state == ST_LOAD) && wt_in_valid;
  assign issue    = (state == ST_RUN) && !run_stall;

  assign wt_in_ready = (state == ST_LOAD);
  assign busy        = (state == ST_LOAD) || (state == ST_RUN);
  assign wt_out_data = tbl_dout;

  cnn_layer_accel_awe_rd_ctr #(
    .W_DEPTH (W_DEPTH),
    .P_WIDTH (P_WIDTH)
  ) u_rd_ctr (
    .clk        (clk),
    .rst        (rst),
    .clear      (run_go),
    .advance    (issue),
    .num_wts    (num_wts),
    .num_passes (num_passes),
    .addr       (rd_addr),
    .last       (rd_last),
    .last_pass  (rd_last_pass)
  );

  // Control FSM plus the one-stage issued-read flag pipeline matching RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      num_wts          <= '0;
      wr_ptr           <= '0;
      num_passes       <= '0;
      wt_out_valid     <= 1'b0;
      wt_out_last      <= 1'b0;
      wt_out_last_pass <= 1'b0;
      done             <= 1'b0;
    end else begin
      wt_out_valid     <= issue;
      wt_out_last      <= issue && rd_last;
      wt_out_last_pass <= issue && rd_last && rd_last_pass;
      done             <= issue && rd_last && rd_last_pass;
      case (state)
        ST_IDLE: begin
          if (cfg_ok) begin
            num_wts <= cfg_num_wts;
            wr_ptr  <= '0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (wr_ptr == num_wts - PTR_ONE) state <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (cfg_ok) begin
            num_wts <= cfg_num_wts;
            wr_ptr  <= '0;
            state   <= ST_LOAD;
          end else if (run_go) begin
            num_passes <= run_num_passes;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue && rd_last && rd_last_pass) state <= ST_LOADED;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Table port: write path driven straight from the load stream, read address in RUN.
  always_comb begin
    tbl_we   = 1'b0;
    tbl_addr = '0;
    tbl_din  = '0;
    case (state)
      ST_LOAD: begin
        if (wt_in_valid) begin
          tbl_we   = 1'b1;
          tbl_addr = wr_ptr[W_DEPTH-1:0];
          tbl_din  = wt_in_data;
        end
      end
      ST_RUN:  tbl_addr = rd_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_accel_awe_weight_seq.sv
// Self-checking bench for the AWE weight sequencer with a behavioural weight table.
module tb_cnn_layer_accel_awe_weight_seq;

  localparam int WIDTH   = 32;
  localparam int N_DEPTH = 256;
  localparam int W_DEPTH = 8;
  localparam int P_WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [W_DEPTH:0]   cfg_num_wts;
  logic               wt_in_valid;
  logic [WIDTH-1:0]   wt_in_data;
  logic               wt_in_ready;
  logic               run_start;
  logic [P_WIDTH-1:0] run_num_passes;
  logic               run_stall;
  logic               wt_out_valid;
  logic [WIDTH-1:0]   wt_out_data;
  logic               wt_out_last;
  logic               wt_out_last_pass;
  logic               busy;
  logic               done;
  logic [W_DEPTH-1:0] tbl_addr;
  logic               tbl_we;
  logic [WIDTH-1:0]   tbl_din;
  logic [WIDTH-1:0]   tbl_dout;

  cnn_layer_accel_awe_weight_seq #(
    .WIDTH   (WIDTH),
    .N_DEPTH (N_DEPTH),
    .W_DEPTH (W_DEPTH),
    .P_WIDTH (P_WIDTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_load         (cfg_load),
    .cfg_num_wts      (cfg_num_wts),
    .wt_in_valid      (wt_in_valid),
    .wt_in_data       (wt_in_data),
    .wt_in_ready      (wt_in_ready),
    .run_start        (run_start),
    .run_num_passes   (run_num_passes),
    .run_stall        (run_stall),
    .wt_out_valid     (wt_out_valid),
    .wt_out_data      (wt_out_data),
    .wt_out_last      (wt_out_last),
    .wt_out_last_pass (wt_out_last_pass),
    .busy             (busy),
    .done             (done),
    .tbl_addr         (tbl_addr),
    .tbl_we           (tbl_we),
    .tbl_din          (tbl_din),
    .tbl_dout         (tbl_dout)
  );

  always #5 clk = ~clk;

  // Weight table model: 1-cycle registered read.
  logic [WIDTH-1:0] mem [0:N_DEPTH-1];
  always @(posedge clk) begin
    if (tbl_we) mem[tbl_addr] <= tbl_din;
    tbl_dout <= mem[tbl_addr];
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             lp;
  } out_t;

  typedef struct packed {
    logic [W_DEPTH-1:0] addr;
    logic [WIDTH-1:0]   data;
  } wr_t;

  typedef struct {
    int nw;
    int passes;
    int base;
    int sa;
    int sl;
    bit accept;
    bit gap;
  } vec_t;

  out_t oq[$];
  wr_t  wq[$];
  out_t o;
  wr_t  w;
  int   checks = 0;
  int   errors = 0;
  int   nvalid = 0;
  int   ndone  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: table writes and replayed words are popped as the DUT produces them.
  always @(negedge clk) begin
    if (tbl_we) begin
      if (wq.size() == 0) chk("unexpected_write", tbl_we, 1'b0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", tbl_addr, w.addr);
        chk("wr_data", tbl_din, w.data);
      end
    end
    if (wt_out_valid) begin
      nvalid++;
      if (done) ndone++;
      if (oq.size() == 0) chk("unexpected_out", wt_out_valid, 1'b0);
      else begin
        o = oq.pop_front();
        chk("out_data", wt_out_data, o.data);
        chk("out_last", wt_out_last, o.last);
        chk("out_last_pass", wt_out_last_pass, o.lp);
        chk("out_done", done, o.lp);
      end
    end else if (done) begin
      chk("done_without_valid", done, 1'b0);
    end
  end

  task automatic cfg(input int nw);
    cfg_num_wts = (W_DEPTH+1)'(nw);
    cfg_load    = 1'b1;
    @(posedge clk); #1;
    cfg_load    = 1'b0;
  endtask

  task automatic load_words(input int nw, input int base, input bit gap);
    for (int i = 0; i < nw; i++) begin
      if (gap && i == 2) begin
        wt_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == 0) chk("ready_in_load", wt_in_ready, 1'b1);
      wt_in_data  = WIDTH'(base + i);
      wt_in_valid = 1'b1;
      wq.push_back('{addr: W_DEPTH'(i), data: WIDTH'(base + i)});
      @(posedge clk); #1;
    end
    wt_in_valid = 1'b0;
    chk("ready_after_load", wt_in_ready, 1'b0);
    chk("busy_after_load", busy, 1'b0);
    chk("wr_queue_drained", wq.size(), 0);
  endtask

  task automatic run(input int nw, input int passes, input int base, input int sa, input int sl);
    int issued;
    int stalled;
    int rc;
    int total;
    nvalid = 0;
    ndone  = 0;
    total  = nw * passes;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < nw; i++)
        oq.push_back('{data: WIDTH'(base + i), last: (i == nw - 1),
                       lp: (i == nw - 1) && (p == passes - 1)});
    run_num_passes = P_WIDTH'(passes);
    run_start      = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    issued  = 0;
    stalled = 0;
    rc      = 0;
    while (issued < total) begin
      if (rc == 0) chk("latency_c1", wt_out_valid, 1'b0);
      if (rc == 1 && sa > 0) chk("latency_c2", wt_out_valid, 1'b1);
      if (issued == sa && stalled < sl) begin
        run_stall = 1'b1;
        stalled++;
      end else begin
        run_stall = 1'b0;
        issued++;
      end
      @(posedge clk); #1;
      rc++;
    end
    run_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("run_valid_count", nvalid, total);
    chk("run_done_count", ndone, 1);
    chk("run_queue_drained", oq.size(), 0);
    chk("run_end_busy", busy, 1'b0);
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{nw: 0,   passes: 1, base: 0,      sa: 0,   sl: 0, accept: 1'b0, gap: 1'b0};
    vt[1] = '{nw: 257, passes: 1, base: 0,      sa: 0,   sl: 0, accept: 1'b0, gap: 1'b0};
    vt[2] = '{nw: 9,   passes: 2, base: 'h10,   sa: 100, sl: 0, accept: 1'b1, gap: 1'b0};
    vt[3] = '{nw: 9,   passes: 1, base: 'h40,   sa: 5,   sl: 3, accept: 1'b1, gap: 1'b1};
    vt[4] = '{nw: 1,   passes: 3, base: 'h77,   sa: 1,   sl: 2, accept: 1'b1, gap: 1'b0};
    vt[5] = '{nw: 5,   passes: 2, base: 'h500,  sa: 0,   sl: 2, accept: 1'b1, gap: 1'b0};
    vt[6] = '{nw: 256, passes: 2, base: 'h1000, sa: 300, sl: 2, accept: 1'b1, gap: 1'b0};

    rst = 1'b1; cfg_load = 1'b0; cfg_num_wts = '0; wt_in_valid = 1'b0; wt_in_data = '0;
    run_start = 1'b0; run_num_passes = '0; run_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {wt_in_ready, wt_out_valid, wt_out_last, wt_out_last_pass, busy,
                          done, tbl_we, tbl_addr, tbl_din}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      cfg(vt[k].nw);
      chk("cfg_accept", busy, vt[k].accept);
      if (vt[k].accept) begin
        load_words(vt[k].nw, vt[k].base, vt[k].gap);
        run(vt[k].nw, vt[k].passes, vt[k].base, vt[k].sa, vt[k].sl);
      end
    end

    // Replay the full-depth kernel again without reloading.
    run(256, 1, 'h1000, 10, 1);

    // Simultaneous cfg_load and run_start in LOADED: the reload wins.
    cfg_num_wts    = (W_DEPTH+1)'(3);
    cfg_load       = 1'b1;
    run_num_passes = P_WIDTH'(1);
    run_start      = 1'b1;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    run_start = 1'b0;
    chk("sim_busy", busy, 1'b1);
    chk("sim_ready", wt_in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("sim_no_replay", wt_out_valid, 1'b0);
    load_words(3, 'h200, 1'b0);
    run(3, 1, 'h200, 100, 0);

    // Reset in the middle of a replay.
    cfg(4);
    load_words(4, 'h300, 1'b0);
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 4; i++)
        oq.push_back('{data: WIDTH'('h300 + i), last: (i == 3), lp: (i == 3) && (p == 4)});
    run_num_passes = P_WIDTH'(5);
    run_start      = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrun_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_rst_outputs", {wt_in_ready, wt_out_valid, wt_out_last, wt_out_last_pass, busy,
                               done, tbl_we, tbl_addr, tbl_din}, '0);
    rst = 1'b0;
    oq.delete();
    run_num_passes = P_WIDTH'(1);
    run_start      = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_valid", wt_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
